// File: rtl/parking_gate_controller.sv
// Entry/exit lane sequencer for the normal parking area: arbitrates the shared lane, drives the barrier, and
// emits one entry/exit pulse per completed passage. Define GATE_TIMEOUT_EN to enable the barrier timeout.
module parking_gate_controller #(
    parameter int MAXIMUM      = 20,
    parameter int GATE_TIMEOUT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_passed,
    input  logic [4:0] slots,
    output logic       gate_open,
    output logic       dir_in,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       timeout_pulse,
    output logic       lot_full,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_in;
    logic   w_last_in_next;
    logic   r_gate_open;
    logic   r_dir_in;
    logic   r_entry_pulse;
    logic   r_exit_pulse;
    logic   r_lot_full;
    logic   r_busy;
    logic   w_entry_ok;
    logic   w_exit_ok;
    logic   w_is_open;
    logic   w_entry_done;
    logic   w_exit_done;
    logic   w_timeout;
    logic   w_timer_hit;

    // Eligibility looks at the live slot count, not the registered lot_full flag.
    assign w_entry_ok = entry_req && (slots != 5'd0);
    assign w_exit_ok  = exit_req  && (slots != 5'(MAXIMUM));
    assign w_is_open  = (r_state == OPEN_IN) || (r_state == OPEN_OUT);

`ifdef GATE_TIMEOUT_EN
    logic [5:0] r_timer;
    logic [5:0] w_timer_next;
    logic       r_timeout_pulse;

    // Held at zero outside OPEN, so every OPEN visit starts counting from 0.
    assign w_timer_next = w_is_open ? (r_timer + 6'd1) : 6'd0;
    assign w_timer_hit  = w_is_open && (r_timer == 6'(GATE_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer         <= 6'd0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timer         <= w_timer_next;
            r_timeout_pulse <= w_timeout;
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    // GATE_TIMEOUT stays in the parameter list so both builds share one interface.
    assign w_timer_hit   = 1'b0 && (GATE_TIMEOUT != 0);
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next_state   = r_state;
        w_last_in_next = r_last_in;
        w_entry_done   = 1'b0;
        w_exit_done    = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the direction not granted last time wins.
                if (w_entry_ok && (!w_exit_ok || !r_last_in)) begin
                    w_next_state   = OPEN_IN;
                    w_last_in_next = 1'b1;
                end else if (w_exit_ok) begin
                    w_next_state   = OPEN_OUT;
                    w_last_in_next = 1'b0;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (car_passed) begin
                    w_next_state = CLOSE;
                    w_entry_done = (r_state == OPEN_IN);
                    w_exit_done  = (r_state == OPEN_OUT);
                end else if (w_timer_hit) begin
                    w_next_state = CLOSE;
                    w_timeout    = 1'b1;
                end
            end
            CLOSE: begin
                if (!car_passed) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state       <= IDLE;
            r_last_in     <= 1'b0;
            r_gate_open   <= 1'b0;
            r_dir_in      <= 1'b0;
            r_entry_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
            r_lot_full    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_last_in     <= w_last_in_next;
            r_gate_open   <= (w_next_state == OPEN_IN) || (w_next_state == OPEN_OUT);
            r_dir_in      <= (w_next_state == OPEN_IN);
            r_entry_pulse <= w_entry_done;
            r_exit_pulse  <= w_exit_done;
            r_lot_full    <= (slots == 5'd0);
            r_busy        <= (w_next_state != IDLE);
        end
    end

    assign gate_open   = r_gate_open;
    assign dir_in      = r_dir_in;
    assign entry_pulse = r_entry_pulse;
    assign exit_pulse  = r_exit_pulse;
    assign lot_full    = r_lot_full;
    assign busy        = r_busy;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed self-checking bench for parking_gate_controller; the timeout scenario follows GATE_TIMEOUT_EN.
module tb_parking_gate_controller;

    localparam int MAXIMUM      = 20;
    localparam int GATE_TIMEOUT = 50;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       entry_req  = 1'b0;
    logic       exit_req   = 1'b0;
    logic       car_passed = 1'b0;
    logic [4:0] slots      = 5'd0;
    logic       gate_open;
    logic       dir_in;
    logic       entry_pulse;
    logic       exit_pulse;
    logic       timeout_pulse;
    logic       lot_full;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_entry = 0;
    int n_exit  = 0;
    int n_to    = 0;
    int n_both  = 0;

    parking_gate_controller #(
        .MAXIMUM      (MAXIMUM),
        .GATE_TIMEOUT (GATE_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .car_passed    (car_passed),
        .slots         (slots),
        .gate_open     (gate_open),
        .dir_in        (dir_in),
        .entry_pulse   (entry_pulse),
        .exit_pulse    (exit_pulse),
        .timeout_pulse (timeout_pulse),
        .lot_full      (lot_full),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Pulse tally sampled on the falling edge, away from output updates.
    always @(negedge clk) begin
        if (!reset) begin
            if (entry_pulse === 1'b1) n_entry++;
            if (exit_pulse === 1'b1) n_exit++;
            if (timeout_pulse === 1'b1) n_to++;
            if (entry_pulse === 1'b1 && exit_pulse === 1'b1) n_both++;
        end
    end

    task automatic apply_reset();
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        slots = 5'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({gate_open, dir_in, entry_pulse, exit_pulse, timeout_pulse, lot_full, busy} !== 7'b0)
            $display("FAIL reset_outputs got=%b want=0000000",
                     {gate_open, dir_in, entry_pulse, exit_pulse, timeout_pulse, lot_full, busy});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (lot_full !== 1'b0) $display("FAIL reset_lot_full_before_clock got=%b want=0", lot_full);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (lot_full !== 1'b1) $display("FAIL lot_full_after_clock got=%b want=1", lot_full);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
        else n_pass++;
    endtask

    task automatic test_entry();
        int e0, x0;
        apply_reset();
        slots = 5'd20; entry_req = 1'b1;
        e0 = n_entry; x0 = n_exit;
        @(negedge clk);
        n_total++;
        if ({gate_open, dir_in, busy} !== 3'b111)
            $display("FAIL entry_grant gate_open,dir_in,busy got=%b want=111", {gate_open, dir_in, busy});
        else n_pass++;
        repeat (4) @(negedge clk);
        car_passed = 1'b1;
        @(negedge clk);
        n_total++;
        if ({gate_open, entry_pulse, exit_pulse, busy} !== 4'b0101)
            $display("FAIL entry_pass gate_open,entry,exit,busy got=%b want=0101",
                     {gate_open, entry_pulse, exit_pulse, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({entry_pulse, busy} !== 2'b01)
            $display("FAIL entry_pulse_width entry,busy got=%b want=01", {entry_pulse, busy});
        else n_pass++;
        @(negedge clk);
        car_passed = 1'b0; entry_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({gate_open, busy} !== 2'b00)
            $display("FAIL entry_back_to_idle gate_open,busy got=%b want=00", {gate_open, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ((n_entry - e0) !== 1 || (n_exit - x0) !== 0)
            $display("FAIL entry_pulse_count entry=%0d exit=%0d want 1 0", n_entry - e0, n_exit - x0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic exp_in;
        apply_reset();
        slots = 5'd12; entry_req = 1'b1; exit_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_in = (i % 2 == 0);
            for (int k = 0; k < 10 && gate_open !== 1'b1; k++) @(negedge clk);
            n_total++;
            if (gate_open !== 1'b1 || dir_in !== exp_in)
                $display("FAIL rr_grant_%0d gate_open=%b dir_in=%b want 1 %b", i, gate_open, dir_in, exp_in);
            else n_pass++;
            car_passed = 1'b1;
            @(negedge clk);
            n_total++;
            if (entry_pulse !== exp_in || exit_pulse !== !exp_in)
                $display("FAIL rr_pulse_%0d entry=%b exit=%b want %b %b", i, entry_pulse, exit_pulse,
                         exp_in, !exp_in);
            else n_pass++;
            car_passed = 1'b0;
            @(negedge clk);
        end
        entry_req = 1'b0; exit_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full();
        apply_reset();
        slots = 5'd0; entry_req = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({gate_open, busy, lot_full} !== 3'b001)
            $display("FAIL full_no_entry gate_open,busy,lot_full got=%b want=001", {gate_open, busy, lot_full});
        else n_pass++;
        exit_req = 1'b1;
        @(negedge clk);
        n_total++;
        if ({gate_open, dir_in} !== 2'b10)
            $display("FAIL full_exit_grant gate_open,dir_in got=%b want=10", {gate_open, dir_in});
        else n_pass++;
        car_passed = 1'b1;
        @(negedge clk);
        n_total++;
        if ({entry_pulse, exit_pulse} !== 2'b01)
            $display("FAIL full_exit_pulse entry,exit got=%b want=01", {entry_pulse, exit_pulse});
        else n_pass++;
        car_passed = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_empty();
        apply_reset();
        slots = 5'd20; exit_req = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({gate_open, busy, lot_full} !== 3'b000)
            $display("FAIL empty_no_exit gate_open,busy,lot_full got=%b want=000", {gate_open, busy, lot_full});
        else n_pass++;
        slots = 5'd19;
        @(negedge clk);
        n_total++;
        if ({gate_open, dir_in} !== 2'b10)
            $display("FAIL one_car_exit_grant gate_open,dir_in got=%b want=10", {gate_open, dir_in});
        else n_pass++;
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0; exit_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int e0, x0, t0, open_cycles;
        apply_reset();
        slots = 5'd10; entry_req = 1'b1;
        e0 = n_entry; x0 = n_exit; t0 = n_to;
        for (int k = 0; k < 5 && gate_open !== 1'b1; k++) @(negedge clk);
`ifdef GATE_TIMEOUT_EN
        open_cycles = 0;
        while (gate_open === 1'b1 && open_cycles < 200) begin
            open_cycles++;
            entry_req = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (open_cycles !== GATE_TIMEOUT)
            $display("FAIL timeout_open_cycles got=%0d want=%0d", open_cycles, GATE_TIMEOUT);
        else n_pass++;
        n_total++;
        if ({gate_open, timeout_pulse, entry_pulse, exit_pulse} !== 4'b0100)
            $display("FAIL timeout_pulse gate_open,timeout,entry,exit got=%b want=0100",
                     {gate_open, timeout_pulse, entry_pulse, exit_pulse});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({timeout_pulse, busy} !== 2'b00)
            $display("FAIL timeout_after timeout,busy got=%b want=00", {timeout_pulse, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ((n_to - t0) !== 1 || (n_entry - e0) !== 0 || (n_exit - x0) !== 0)
            $display("FAIL timeout_counts to=%0d entry=%0d exit=%0d want 1 0 0", n_to - t0, n_entry - e0,
                     n_exit - x0);
        else n_pass++;
`else
        open_cycles = 0;
        entry_req = 1'b0;
        repeat (70) @(negedge clk);
        n_total++;
        if ({gate_open, busy, timeout_pulse} !== 3'b110 || (n_to - t0) !== 0)
            $display("FAIL no_timeout_hold gate_open,busy,timeout got=%b to=%0d want 110 0",
                     {gate_open, busy, timeout_pulse}, n_to - t0);
        else n_pass++;
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ((n_entry - e0) !== 1 || busy !== 1'b0)
            $display("FAIL no_timeout_pass entry=%0d busy=%b want 1 0", n_entry - e0, busy);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        slots = 5'd10; entry_req = 1'b1;
        for (int k = 0; k < 5 && gate_open !== 1'b1; k++) @(negedge clk);
        car_passed = 1'b1;
        @(negedge clk);
        n_total++;
        if (entry_pulse !== 1'b1) $display("FAIL mid_reset_setup entry_pulse got=%b want=1", entry_pulse);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({gate_open, dir_in, entry_pulse, exit_pulse, timeout_pulse, lot_full, busy} !== 7'b0)
            $display("FAIL mid_reset_outputs got=%b want=0000000",
                     {gate_open, dir_in, entry_pulse, exit_pulse, timeout_pulse, lot_full, busy});
        else n_pass++;
        @(negedge clk);
        car_passed = 1'b0; exit_req = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({gate_open, dir_in} !== 2'b11)
            $display("FAIL mid_reset_last_grant gate_open,dir_in got=%b want=11", {gate_open, dir_in});
        else n_pass++;
        car_passed = 1'b1;
        @(negedge clk);
        car_passed = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_round_robin();
        test_full();
        test_empty();
        test_timeout();
        test_reset_mid();
        n_total++;
        if (n_both !== 0) $display("FAIL pulses_exclusive overlaps=%0d want=0", n_both);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
